// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one byte-oriented I2C master between N_REQ clients.
// Define I2C_TIMEOUT_EN to add a command-to-response watchdog that aborts stalled transactions.
module i2c_txn_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_rnw,
    input  logic [7*N_REQ-1:0] req_addr,
    input  logic [8*N_REQ-1:0] req_reg,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   req_done,
    output logic [7:0]         rsp_rdata,
    output logic               rsp_err,
    output logic               m_cmd_valid,
    input  logic               m_cmd_ready,
    output logic               m_cmd_rnw,
    output logic [6:0]         m_cmd_addr,
    output logic [7:0]         m_cmd_reg,
    output logic [7:0]         m_cmd_wdata,
    input  logic               m_rsp_valid,
    input  logic [7:0]         m_rsp_rdata,
    input  logic               m_rsp_nack,
    output logic               m_abort
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] pick;
    logic             pick_found;
    logic [IDX_W:0]   cand;

    // First requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!pick_found && req_valid[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick       = cand[IDX_W-1:0];
            end
        end
    end

`ifdef I2C_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // Asserted on the edge where the counter would reach TIMEOUT_CYC.
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign m_abort        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            grant       <= '0;
            req_done    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            m_cmd_valid <= 1'b0;
            m_cmd_rnw   <= 1'b0;
            m_cmd_addr  <= '0;
            m_cmd_reg   <= '0;
            m_cmd_wdata <= '0;
`ifdef I2C_TIMEOUT_EN
            tmo_cnt     <= '0;
            m_abort     <= 1'b0;
`endif
        end else begin
`ifdef I2C_TIMEOUT_EN
            m_abort <= 1'b0;
            if (state == ISSUE || state == WAIT) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
`endif
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner       <= pick;
                        grant       <= '0;
                        grant[pick] <= 1'b1;
                        m_cmd_valid <= 1'b1;
                        m_cmd_rnw   <= req_rnw[pick];
                        m_cmd_addr  <= req_addr[7*pick +: 7];
                        m_cmd_reg   <= req_reg[8*pick +: 8];
                        m_cmd_wdata <= req_wdata[8*pick +: 8];
                        state       <= ISSUE;
`ifdef I2C_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end
                ISSUE: begin
`ifdef I2C_TIMEOUT_EN
                    if (tmo_hit) begin
                        m_cmd_valid     <= 1'b0;
                        m_abort         <= 1'b1;
                        rsp_rdata       <= 8'h00;
                        rsp_err         <= 1'b1;
                        req_done[owner] <= 1'b1;
                        state           <= DONE;
                    end else
`endif
                    if (m_cmd_ready) begin
                        m_cmd_valid <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // A response landing on the timeout edge still completes normally.
                    if (m_rsp_valid) begin
                        rsp_rdata       <= m_cmd_rnw ? m_rsp_rdata : 8'h00;
                        rsp_err         <= m_rsp_nack;
                        req_done[owner] <= 1'b1;
                        state           <= DONE;
                    end
`ifdef I2C_TIMEOUT_EN
                    else if (tmo_hit) begin
                        m_abort         <= 1'b1;
                        rsp_rdata       <= 8'h00;
                        rsp_err         <= 1'b1;
                        req_done[owner] <= 1'b1;
                        state           <= DONE;
                    end
`endif
                end
                default: begin
                    grant    <= '0;
                    req_done <= '0;
                    ptr      <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: vector table of single transactions, hand-written corner
// sequences, and a randomized run scored against a round-robin transaction model.
`timescale 1ns/1ps
module tb_i2c_txn_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_rnw;
    logic [7*N-1:0] req_addr;
    logic [8*N-1:0] req_reg;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]   grant;
    logic [N-1:0]   req_done;
    logic [7:0]     rsp_rdata;
    logic           rsp_err;
    logic           m_cmd_valid;
    logic           m_cmd_ready;
    logic           m_cmd_rnw;
    logic [6:0]     m_cmd_addr;
    logic [7:0]     m_cmd_reg;
    logic [7:0]     m_cmd_wdata;
    logic           m_rsp_valid;
    logic [7:0]     m_rsp_rdata;
    logic           m_rsp_nack;
    logic           m_abort;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rnw(req_rnw), .req_addr(req_addr),
        .req_reg(req_reg), .req_wdata(req_wdata),
        .grant(grant), .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_rnw(m_cmd_rnw),
        .m_cmd_addr(m_cmd_addr), .m_cmd_reg(m_cmd_reg), .m_cmd_wdata(m_cmd_wdata),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .m_rsp_nack(m_rsp_nack),
        .m_abort(m_abort)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] pend, input int from);
        for (int k = 0; k < N; k++) begin
            if (pend[(from + k) % N]) return (from + k) % N;
        end
        return 0;
    endfunction

    task automatic set_client(input int c, input logic rnw, input logic [6:0] a,
                              input logic [7:0] r, input logic [7:0] w);
        req_rnw[c]           = rnw;
        req_addr[7*c +: 7]   = a;
        req_reg[8*c +: 8]    = r;
        req_wdata[8*c +: 8]  = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drives the master side of one transaction that is already arbitrated or about to be.
    task automatic serve(input int rdy_dly, input logic [7:0] rd, input logic nk,
                         output logic [N-1:0] gnt, output logic [23:0] cmd);
        int w = 0;
        while (m_cmd_valid !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        check("cmd_valid_seen", m_cmd_valid, 1'b1);
        gnt = grant;
        cmd = {m_cmd_rnw, m_cmd_addr, m_cmd_reg, m_cmd_wdata};
        for (int k = 0; k < rdy_dly; k++) begin
            tick();
            check("cmd_stable", {m_cmd_valid, m_cmd_rnw, m_cmd_addr, m_cmd_reg, m_cmd_wdata},
                  {1'b1, cmd});
        end
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        check("cmd_valid_drop", m_cmd_valid, 1'b0);
        tick();
        check("no_early_done", req_done, '0);
        m_rsp_valid = 1'b1;
        m_rsp_rdata = rd;
        m_rsp_nack  = nk;
        tick();
        m_rsp_valid = 1'b0;
        m_rsp_rdata = 8'h00;
        m_rsp_nack  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    end

    typedef struct {
        int         client;
        logic       rnw;
        logic [6:0] addr;
        logic [7:0] rg;
        logic [7:0] wd;
        int         rdy;
        logic [7:0] mrd;
        logic       mnk;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t vec [5];

    logic [N-1:0] gnt;
    logic [23:0]  cmd;
    logic [N-1:0] order_exp [6];
    logic [N-1:0] rereq;
    int           c;
    int           k;
    int           cyc;
    int           left;
    int           total;
    int           completions;
    int           ph;
    int           owner;
    int           mptr;
    int           iss_wait;
    int           rsp_wait;
    int           remaining [N];
    int           gap [N];
    logic [N-1:0] req_s;
    logic         rdy_s;
    logic         rspv_s;
    logic [7:0]   rd_s;
    logic         nk_s;
    logic [7:0]   held_rd;
    logic         held_err;
    logic [23:0]  exp_cmd;

    initial begin
        vec[0] = '{1, 1'b1, 7'h68, 8'h75, 8'h00, 0, 8'h68, 1'b0, 8'h68, 1'b0};
        vec[1] = '{2, 1'b0, 7'h50, 8'h6B, 8'hA5, 1, 8'h3C, 1'b1, 8'h00, 1'b1};
        vec[2] = '{0, 1'b1, 7'h77, 8'hF6, 8'h12, 5, 8'h9E, 1'b0, 8'h9E, 1'b0};
        vec[3] = '{3, 1'b0, 7'h1E, 8'h20, 8'h5A, 2, 8'hFF, 1'b0, 8'h00, 1'b0};
        vec[4] = '{3, 1'b1, 7'h7F, 8'h00, 8'hFF, 0, 8'hC3, 1'b1, 8'hC3, 1'b1};
        order_exp = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};

        req_rnw = '0; req_addr = '0; req_reg = '0; req_wdata = '0;
        m_rsp_rdata = 8'h00; m_rsp_nack = 1'b0;
        do_reset();
        check("rst_ctrl", {grant, req_done, rsp_rdata, rsp_err, m_cmd_valid, m_abort}, '0);
        check("rst_cmd", {m_cmd_rnw, m_cmd_addr, m_cmd_reg, m_cmd_wdata}, '0);

        for (int i = 0; i < 5; i++) begin
            set_client(vec[i].client, vec[i].rnw, vec[i].addr, vec[i].rg, vec[i].wd);
            req_valid[vec[i].client] = 1'b1;
            tick();
            check("cmd_latency", m_cmd_valid, 1'b1);
            serve(vec[i].rdy, vec[i].mrd, vec[i].mnk, gnt, cmd);
            check("vec_grant", gnt, oh(vec[i].client));
            check("vec_cmd", cmd, {vec[i].rnw, vec[i].addr, vec[i].rg, vec[i].wd});
            check("vec_done", req_done, oh(vec[i].client));
            check("vec_grant_in_done", grant, oh(vec[i].client));
            check("vec_rdata", rsp_rdata, vec[i].exp_rd);
            check("vec_err", rsp_err, vec[i].exp_err);
            req_valid[vec[i].client] = 1'b0;
            tick();
            check("vec_release", {grant, req_done}, '0);
            check("vec_rsp_held", {rsp_err, rsp_rdata}, {vec[i].exp_err, vec[i].exp_rd});
        end

        // Three simultaneous requesters, each re-requesting once.
        do_reset();
        set_client(0, 1'b1, 7'h10, 8'h01, 8'h00);
        set_client(2, 1'b0, 7'h22, 8'h02, 8'h33);
        set_client(3, 1'b1, 7'h33, 8'h03, 8'h00);
        req_valid = 4'b1101;
        rereq     = 4'b1101;
        tick();
        for (int t = 0; t < 6; t++) begin
            serve(0, 8'h40 + 8'(t), 1'b0, gnt, cmd);
            check("rr_order", gnt, order_exp[t]);
            check("rr_done", req_done, order_exp[t]);
            c = rr_pick(order_exp[t], 0);
            req_valid[c] = 1'b0;
            tick();
            if (rereq[c]) begin
                rereq[c]     = 1'b0;
                req_valid[c] = 1'b1;
            end
        end
        tick();
        check("rr_drained", {m_cmd_valid, grant}, '0);

        // Requester drops req_valid mid-transaction; completion still reported.
        set_client(1, 1'b1, 7'h0C, 8'h44, 8'h00);
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        serve(2, 8'h5D, 1'b0, gnt, cmd);
        check("drop_done", req_done, 4'b0010);
        check("drop_rdata", rsp_rdata, 8'h5D);
        tick();
        tick();
        check("drop_no_regrant", {m_cmd_valid, grant}, '0);

        // Reset while waiting for a response; the late response must be ignored.
        set_client(2, 1'b1, 7'h2A, 8'h10, 8'h00);
        req_valid[2] = 1'b1;
        tick();
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        check("wait_entered", m_cmd_valid, 1'b0);
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ctrl", {grant, req_done, rsp_rdata, rsp_err, m_cmd_valid, m_abort}, '0);
        check("midrst_cmd", {m_cmd_rnw, m_cmd_addr, m_cmd_reg, m_cmd_wdata}, '0);
        m_rsp_valid = 1'b1;
        m_rsp_rdata = 8'hEE;
        tick();
        m_rsp_valid = 1'b0;
        tick();
        check("late_rsp_ignored", {req_done, rsp_err, rsp_rdata, m_cmd_valid, grant}, '0);
        set_client(0, 1'b0, 7'h01, 8'h02, 8'h03);
        set_client(3, 1'b0, 7'h04, 8'h05, 8'h06);
        req_valid = 4'b1001;
        tick();
        check("post_rst_grant", grant, 4'b0001);
        serve(0, 8'h00, 1'b0, gnt, cmd);
        check("post_rst_cmd", cmd, {1'b0, 7'h01, 8'h02, 8'h03});
        req_valid[0] = 1'b0;
        tick();
        serve(0, 8'h00, 1'b0, gnt, cmd);
        check("post_rst_second", gnt, 4'b1000);
        req_valid = '0;
        tick();

`ifdef I2C_TIMEOUT_EN
        // Master accepts the command but never answers.
        set_client(1, 1'b1, 7'h68, 8'h3B, 8'h00);
        req_valid[1] = 1'b1;
        tick();
        k = 0;
        while (m_abort !== 1'b1 && k < 40) begin
            m_cmd_ready = (k == 2);
            tick();
            k++;
        end
        m_cmd_ready = 1'b0;
        check("abort_delay", k, TMO);
        check("abort_done", req_done, 4'b0010);
        check("abort_rsp", {rsp_err, rsp_rdata}, {1'b1, 8'h00});
        req_valid = '0;
        tick();
        check("abort_pulse", {m_abort, req_done}, '0);
`endif

        // Randomized traffic scored against the round-robin model.
        do_reset();
        ph = 0; mptr = 0; owner = 0; completions = 0; total = 0;
        held_rd = 8'h00; held_err = 1'b0; exp_cmd = '0; iss_wait = 0; rsp_wait = 0;
        for (int i = 0; i < N; i++) begin
            remaining[i] = 6;
            gap[i]       = int'($urandom_range(0, 3));
            total       += 6;
        end
        cyc = 0;
        while (cyc < 6000) begin
            req_s  = req_valid;
            rdy_s  = m_cmd_ready;
            rspv_s = m_rsp_valid;
            rd_s   = m_rsp_rdata;
            nk_s   = m_rsp_nack;
            tick();
            cyc++;
            case (ph)
                0: begin
                    if (req_s != '0) begin
                        owner   = rr_pick(req_s, mptr);
                        exp_cmd = {req_rnw[owner], req_addr[7*owner +: 7], req_reg[8*owner +: 8],
                                   req_wdata[8*owner +: 8]};
                        ph       = 1;
                        iss_wait = int'($urandom_range(0, 4));
                        check("rnd_grant", grant, oh(owner));
                        check("rnd_cmd", {m_cmd_valid, m_cmd_rnw, m_cmd_addr, m_cmd_reg, m_cmd_wdata},
                              {1'b1, exp_cmd});
                    end else begin
                        check("rnd_idle", {m_cmd_valid, grant}, '0);
                    end
                end
                1: begin
                    if (rdy_s) begin
                        ph       = 2;
                        rsp_wait = int'($urandom_range(0, 6));
                        check("rnd_accept", {m_cmd_valid, grant}, {1'b0, oh(owner)});
                    end else begin
                        check("rnd_hold", {m_cmd_valid, m_cmd_rnw, m_cmd_addr, m_cmd_reg, m_cmd_wdata},
                              {1'b1, exp_cmd});
                    end
                end
                2: begin
                    if (rspv_s) begin
                        ph       = 3;
                        held_rd  = exp_cmd[23] ? rd_s : 8'h00;
                        held_err = nk_s;
                        completions++;
                        check("rnd_done", req_done, oh(owner));
                        check("rnd_rsp", {rsp_err, rsp_rdata}, {held_err, held_rd});
                    end else begin
                        check("rnd_wait", {m_cmd_valid, req_done, grant}, {1'b0, 4'b0000, oh(owner)});
                    end
                end
                default: begin
                    ph   = 0;
                    mptr = (owner + 1) % N;
                    check("rnd_release", {grant, req_done}, '0);
                end
            endcase
            if (ph != 3) check("rnd_rsp_held", {rsp_err, rsp_rdata}, {held_err, held_rd});

            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if (ph == 3 && owner == i) begin
                        req_valid[i] = 1'b0;
                        remaining[i]--;
                        gap[i] = int'($urandom_range(0, 3));
                    end
                end else if (remaining[i] > 0) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else begin
                        set_client(i, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom),
                                   8'($urandom));
                        req_valid[i] = 1'b1;
                    end
                end
            end
            if (ph == 1) begin
                m_cmd_ready = (iss_wait == 0);
                if (iss_wait > 0) iss_wait--;
            end else begin
                m_cmd_ready = 1'($urandom_range(0, 1));
            end
            m_rsp_rdata = 8'($urandom);
            m_rsp_nack  = 1'($urandom_range(0, 1));
            if (ph == 2) begin
                m_rsp_valid = (rsp_wait == 0);
                if (rsp_wait > 0) rsp_wait--;
            end else begin
                m_rsp_valid = ($urandom_range(0, 7) == 0);
            end

            left = 0;
            for (int i = 0; i < N; i++) left += remaining[i];
            if (left == 0 && ph == 0) break;
        end
        check("rnd_completions", completions, total);

        req_valid = '0;
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
